// File: rtl/urisc_pkg.sv
//------------------------------------------------------------------------------
// Module   : urisc_pkg
// Purpose  : Shared types and helpers for the parametrised SUBLEQ core:
//            FSM state encoding, halt-address computation and the fixed
//            instruction length (three address words per instruction).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package urisc_pkg;

  // Core sequencer states. The encoding is fixed so that state values seen
  // on a debug probe stay stable across revisions.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_B = 3'd2,
    S_FETCH_C = 3'd3,
    S_READ_A  = 3'd4,
    S_READ_B  = 3'd5,
    S_WRITE   = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  // Branching or falling through to the all-ones address stops the core.
  function automatic logic [63:0] halt_addr(input int unsigned aw);
    return (64'd1 << aw) - 64'd1;
  endfunction

  // Words per instruction: A, B, C.
  function automatic int unsigned instr_len();
    return 3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/urisc_sub_branch.sv
//------------------------------------------------------------------------------
// Module   : urisc_sub_branch
// Purpose  : Combinational SUBLEQ datapath: res = opB - opA (wrapping) and the
//            branch decision take = (res <= 0) in two's complement.
// Ports    : i_op_a  operand M[A]
//            i_op_b  operand M[B]
//            o_res   opB - opA mod 2^DATA_W
//            o_take  1 when res is negative or zero
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module urisc_sub_branch #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic [DATA_W-1:0] o_res,
  output logic              o_take
);

  logic [DATA_W-1:0] w_res;

  assign w_res  = i_op_b - i_op_a;
  assign o_res  = w_res;
  assign o_take = w_res[DATA_W-1] | (w_res == '0);

endmodule

`default_nettype wire

// File: rtl/urisc_core_p.sv
//------------------------------------------------------------------------------
// Module   : urisc_core_p
// Purpose  : Parametrised single-instruction (SUBLEQ) processor core with a
//            single-outstanding req/ack memory port, run/stop at instruction
//            boundaries, halt detection and a saturating retired counter.
// Ports    : clk_PH1            clock, all state on rising edge
//            rst                synchronous active-high reset
//            run                1 = execute, 0 = stop at next boundary
//            mem_req/we/addr/wdata  registered memory request
//            mem_rdata/mem_ack  memory response (ack may be same cycle)
//            busy               not IDLE and not HALT
//            halted             in HALT
//            pc                 current instruction address
//            instr_cnt          retired instructions, saturating
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module urisc_core_p
  import urisc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk_PH1,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam logic [ADDR_W-1:0] C_HALT_ADDR = ADDR_W'(halt_addr(ADDR_W));
  localparam logic [ADDR_W-1:0] C_LEN       = ADDR_W'(instr_len());
  localparam logic [ADDR_W-1:0] C_ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_TWO       = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] C_START     = ADDR_W'(START_ADDR);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_a;
  logic [ADDR_W-1:0] r_b;
  logic [ADDR_W-1:0] r_c;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_ack;
  logic [ADDR_W-1:0] w_rdata_addr;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_res;
  logic              w_take;
  logic [ADDR_W-1:0] w_next;

  // An ack only counts against an outstanding request; stray acks (e.g. a
  // late response to an access abandoned by reset) are dropped here.
  assign w_ack = r_mem_req & mem_ack;

  // Addresses come from the low ADDR_W bits of the fetched word; a word
  // narrower than the address space is zero-extended.
  generate
    if (DATA_W >= ADDR_W) begin : g_addr_slice
      assign w_rdata_addr = mem_rdata[ADDR_W-1:0];
    end else begin : g_addr_zext
      assign w_rdata_addr = {{(ADDR_W-DATA_W){1'b0}}, mem_rdata};
    end
  endgenerate

  // In READ_B the subtractor sees the incoming word so the result can be
  // registered straight into mem_wdata; in WRITE it sees the latched opB,
  // which reproduces the same result for the branch decision.
  assign w_op_b = (r_state == S_READ_B) ? mem_rdata : r_op_b;

  urisc_sub_branch #(
    .DATA_W (DATA_W)
  ) u_branch (
    .i_op_a (r_op_a),
    .i_op_b (w_op_b),
    .o_res  (w_res),
    .o_take (w_take)
  );

  assign w_next = w_take ? r_c : (r_pc + C_LEN);

  always_ff @(posedge clk_PH1) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= C_START;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state    <= S_FETCH_A;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end
        end
        S_FETCH_A: begin
          if (w_ack) begin
            r_a        <= w_rdata_addr;
            r_state    <= S_FETCH_B;
            r_mem_addr <= r_pc + C_ONE;
          end
        end
        S_FETCH_B: begin
          if (w_ack) begin
            r_b        <= w_rdata_addr;
            r_state    <= S_FETCH_C;
            r_mem_addr <= r_pc + C_TWO;
          end
        end
        S_FETCH_C: begin
          if (w_ack) begin
            r_c        <= w_rdata_addr;
            r_state    <= S_READ_A;
            r_mem_addr <= r_a;
          end
        end
        S_READ_A: begin
          if (w_ack) begin
            r_op_a     <= mem_rdata;
            r_state    <= S_READ_B;
            r_mem_addr <= r_b;
          end
        end
        S_READ_B: begin
          if (w_ack) begin
            // mem_wdata doubles as the registered result.
            r_op_b      <= mem_rdata;
            r_mem_wdata <= w_res;
            r_mem_we    <= 1'b1;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_ack) begin
            r_pc     <= w_next;
            r_mem_we <= 1'b0;
            if (r_cnt != '1) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            // Halt takes priority over run; run is only looked at here.
            if (w_next == C_HALT_ADDR) begin
              r_state   <= S_HALT;
              r_mem_req <= 1'b0;
            end else if (run) begin
              r_state    <= S_FETCH_A;
              r_mem_addr <= w_next;
            end else begin
              r_state   <= S_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        S_HALT: begin
          r_mem_req <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted    = (r_state == S_HALT);
  assign pc        = r_pc;
  assign instr_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_urisc_core_p.sv
//------------------------------------------------------------------------------
// Module   : tb_urisc_core_p
// Purpose  : Self-checking bench for urisc_core_p (DATA_W = ADDR_W = 8).
//            Memory model with programmable ack delay; expected writes are
//            queued when a program is loaded and compared as the core writes.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_urisc_core_p;

  logic        clk_PH1 = 1'b0;
  logic        rst     = 1'b1;
  logic        run     = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        halted;
  logic [7:0]  pc;
  logic [15:0] instr_cnt;

  urisc_core_p #(
    .DATA_W     (8),
    .ADDR_W     (8),
    .START_ADDR (0),
    .CNT_W      (16)
  ) dut (
    .clk_PH1   (clk_PH1),
    .rst       (rst),
    .run       (run),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .halted    (halted),
    .pc        (pc),
    .instr_cnt (instr_cnt)
  );

  always #5 clk_PH1 = ~clk_PH1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [7:0] mem [0:255];
  int wait_left = 0;
  int max_delay = 0;
  bit stall_en  = 1'b0;   // hold off the ack of the READ_B access to address 10
  bit stray_ack = 1'b0;   // ack with no request outstanding

  assign mem_ack   = (mem_req && (wait_left == 0) &&
                      !(stall_en && !mem_we && (mem_addr == 8'd10))) || stray_ack;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk_PH1) begin
    if (mem_req && mem_ack) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      wait_left <= (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
    end else if (mem_req && (wait_left > 0)) begin
      wait_left <= wait_left - 1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q [$];
  logic [7:0] hs_log [$];
  int         cyc = 0;
  int         t_req_rise = 0;
  int         t_write = 0;
  bit         prev_req = 1'b0;
  bit         pend = 1'b0;
  logic [7:0] p_addr;
  logic       p_we;
  logic [7:0] p_wdata;

  always @(negedge clk_PH1) begin
    wr_t e;
    cyc++;
    if (mem_req && !prev_req) t_req_rise = cyc;
    if (pend && mem_req) begin
      chk("hold_addr", mem_addr, p_addr);
      chk("hold_we", mem_we, p_we);
      chk("hold_wdata", mem_wdata, p_wdata);
    end
    if (mem_req && mem_ack) begin
      hs_log.push_back(mem_addr);
      if (mem_we) begin
        t_write = cyc;
        if (exp_q.size() == 0) begin
          chk("sb_expected_write", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
        end
      end
    end
    pend     = mem_req && !mem_ack;
    p_addr   = mem_addr;
    p_we     = mem_we;
    p_wdata  = mem_wdata;
    prev_req = mem_req;
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk_PH1);
    rst = 1'b1; run = 1'b0; stray_ack = 1'b0; stall_en = 1'b0;
    @(negedge clk_PH1);
    @(negedge clk_PH1);
    chk("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin @(negedge clk_PH1); n++; end
    chk(tag, busy, 0);
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 400) begin @(negedge clk_PH1); n++; end
    chk(tag, halted, 1);
  endtask

  // Start from IDLE, drop run once the core reads drop_addr, expect one retired
  // instruction ending at exp_pc.
  task automatic run_instr(input logic [7:0] drop_addr, input logic [7:0] first_addr,
                           input logic [7:0] exp_pc, input bit zero_wait);
    int n;
    bit got;
    hs_log.delete();
    @(negedge clk_PH1);
    run = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin @(negedge clk_PH1); n++; got = mem_req; end
    chk("req_after_run", n, 1);
    chk("first_addr", mem_addr, first_addr);
    n = 0; got = 1'b0;
    while (!got && n < 50) begin
      if (mem_req && !mem_we && mem_addr == drop_addr) got = 1'b1;
      else begin @(negedge clk_PH1); n++; end
    end
    chk("drop_point", got, 1);
    run = 1'b0;
    wait_idle("stop_idle");
    chk("stop_pc", pc, exp_pc);
    if (zero_wait) chk("instr_cycles", t_write - t_req_rise + 1, 6);
  endtask

  task automatic load_basic(input logic [7:0] m9, input logic [7:0] m10, input logic [7:0] c);
    mem[0] = 8'd9; mem[1] = 8'd10; mem[2] = c;
    mem[9] = m9;   mem[10] = m10;
  endtask

  task automatic load_p5();
    mem[0]  = 8'd100; mem[1]  = 8'd101; mem[2]  = 8'd3;
    mem[3]  = 8'd102; mem[4]  = 8'd103; mem[5]  = 8'd6;
    mem[6]  = 8'd101; mem[7]  = 8'd104; mem[8]  = 8'd9;
    mem[9]  = 8'd100; mem[10] = 8'd105; mem[11] = 8'd0;
    mem[12] = 8'd104; mem[13] = 8'd104; mem[14] = 8'd255;
    mem[100] = 8'd3;  mem[101] = 8'd10; mem[102] = 8'd5;
    mem[103] = 8'd5;  mem[104] = 8'd2;  mem[105] = 8'h81;
    exp_q.push_back({8'd101, 8'd7});
    exp_q.push_back({8'd103, 8'd0});
    exp_q.push_back({8'd104, 8'hFB});
    exp_q.push_back({8'd105, 8'h7E});
    exp_q.push_back({8'd104, 8'd0});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] snap [0:5];
    int nreq;
    int n;
    bit got;

    // Reset values
    do_reset();
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_cnt", instr_cnt, 0);

    // Basic instruction, zero-wait: 7 - 5 = 2, fall through
    load_basic(8'd5, 8'd7, 8'd99);
    exp_q.push_back({8'd10, 8'd2});
    run_instr(8'd0, 8'd0, 8'd3, 1'b1);
    chk("basic_cnt", instr_cnt, 1);
    chk("basic_mem", mem[10], 8'd2);

    // Zero result branches to C
    do_reset();
    load_basic(8'd7, 8'd7, 8'd99);
    exp_q.push_back({8'd10, 8'd0});
    run_instr(8'd0, 8'd0, 8'd99, 1'b1);

    // 0x80 - 1 wraps to +0x7F: fall through
    do_reset();
    load_basic(8'd1, 8'h80, 8'd99);
    exp_q.push_back({8'd10, 8'h7F});
    run_instr(8'd0, 8'd0, 8'd3, 1'b1);

    // Taken branch to 255 halts; run stays high
    do_reset();
    load_basic(8'd5, 8'd3, 8'd255);
    exp_q.push_back({8'd10, 8'hFE});
    @(negedge clk_PH1);
    run = 1'b1;
    wait_halt("halt_reached");
    chk("halt_pc", pc, 8'd255);
    chk("halt_busy", busy, 0);
    chk("halt_cnt", instr_cnt, 1);
    chk("halt_mem", mem[10], 8'hFE);
    nreq = 0;
    repeat (20) begin @(negedge clk_PH1); if (mem_req) nreq++; end
    chk("halt_no_req", nreq, 0);
    chk("halt_stays", halted, 1);
    run = 1'b0;

    // Reset in READ_B with the ack arriving alongside reset, then stray acks
    do_reset();
    load_basic(8'd5, 8'd7, 8'd99);
    stall_en = 1'b1;
    @(negedge clk_PH1);
    run = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk_PH1); n++;
      got = mem_req && !mem_we && (mem_addr == 8'd10);
    end
    chk("rb_reached", got, 1);
    rst = 1'b1; run = 1'b0; stall_en = 1'b0;
    @(negedge clk_PH1);
    rst = 1'b0; stray_ack = 1'b1;
    chk("rb_rst_req", mem_req, 0);
    chk("rb_rst_pc", pc, 0);
    chk("rb_rst_busy", busy, 0);
    repeat (3) @(negedge clk_PH1);
    chk("rb_late_req", mem_req, 0);
    chk("rb_late_cnt", instr_cnt, 0);
    chk("rb_late_mem", mem[10], 8'd7);
    stray_ack = 1'b0;

    // run dropped during FETCH_B, then restart from the stored pc
    do_reset();
    load_basic(8'd5, 8'd7, 8'd99);
    mem[3] = 8'd20; mem[4] = 8'd21; mem[5] = 8'd6;
    mem[20] = 8'd1; mem[21] = 8'd5;
    exp_q.push_back({8'd10, 8'd2});
    exp_q.push_back({8'd21, 8'd4});
    run_instr(8'd1, 8'd0, 8'd3, 1'b1);
    run_instr(8'd3, 8'd3, 8'd6, 1'b1);
    chk("restart_cnt", instr_cnt, 2);

    // pc = 254 fall-through: fetches wrap to 255 and 0
    do_reset();
    mem[0] = 8'd30; mem[1] = 8'd31; mem[2] = 8'd254;
    mem[30] = 8'd1; mem[31] = 8'd1;
    mem[254] = 8'd40; mem[255] = 8'd41;
    mem[40] = 8'd1; mem[41] = 8'd5;
    exp_q.push_back({8'd31, 8'd0});
    exp_q.push_back({8'd41, 8'd4});
    run_instr(8'd0, 8'd0, 8'd254, 1'b1);
    run_instr(8'd254, 8'd254, 8'd1, 1'b1);
    chk("wrap_hs_n", hs_log.size(), 6);
    if (hs_log.size() >= 3) begin
      chk("wrap_fa", hs_log[0], 8'd254);
      chk("wrap_fb", hs_log[1], 8'd255);
      chk("wrap_fc", hs_log[2], 8'd0);
    end

    // Five-instruction program: zero-wait reference, then random 0-3 wait states
    do_reset();
    max_delay = 0;
    load_p5();
    @(negedge clk_PH1);
    run = 1'b1;
    wait_halt("p5_zw_halt");
    chk("p5_zw_cnt", instr_cnt, 5);
    for (int i = 0; i < 6; i++) snap[i] = mem[100 + i];
    do_reset();
    max_delay = 3;
    load_p5();
    @(negedge clk_PH1);
    run = 1'b1;
    wait_halt("p5_rd_halt");
    chk("p5_rd_cnt", instr_cnt, 5);
    chk("p5_rd_pc", pc, 8'd255);
    for (int i = 0; i < 6; i++) chk("p5_mem_match", mem[100 + i], snap[i]);
    chk("p5_m104", mem[104], 8'd0);
    chk("p5_m105", mem[105], 8'h7E);
    run = 1'b0;
    max_delay = 0;

    do_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
